// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/busy/done handshake.
// Single-cycle add/sub/logic, multi-cycle shift-add multiply and restoring divide.
module alu_seq #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         func,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic               err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] sc_out;
    logic               sc_err;
    logic               launch;

    logic [2*WIDTH-1:0] mul_acc_n;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_n;
    logic [WIDTH-1:0]   div_quo_n;

    assign busy = (state == RUN);

    // Result of the ops that finish in the accepting cycle.
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        sc_out = '0;
        sc_err = 1'b0;
        unique case (func)
            OP_ADD: begin
                sc_out = {{WIDTH{sum[WIDTH-1]}}, sum};
                sc_err = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out = {{WIDTH{diff[WIDTH-1]}}, diff};
                sc_err = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                sc_out = '0;
                sc_err = 1'b0;
            end
            OP_DIV: begin
                sc_out = '1;
                sc_err = 1'b1;
            end
            OP_AND: sc_out = {{WIDTH{1'b0}}, a & b};
            OP_OR:  sc_out = {{WIDTH{1'b0}}, a | b};
            OP_XOR: sc_out = {{WIDTH{1'b0}}, a ^ b};
            OP_ILL: begin
                sc_out = '0;
                sc_err = 1'b1;
            end
            default: begin
                sc_out = '0;
                sc_err = 1'b1;
            end
        endcase
        launch = (func == OP_MUL) ||
                 ((func == OP_DIV) && (b != '0));
    end

    // One multiply / divide iteration from the current registers.
    always_comb begin
        mul_acc_n = acc + (mplier[0] ? mcand : '0);
        div_trial = {rem, quo[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, dvsr});
        div_rem_n = div_ge ? WIDTH'(div_trial - {1'b0, dvsr})
                           : div_trial[WIDTH-1:0];
        div_quo_n = {quo[WIDTH-2:0], div_ge};
    end

    // Handshake FSM, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            done   <= 1'b0;
            out    <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (launch) begin
                            state  <= RUN;
                            cnt    <= '0;
                            is_div <= (func == OP_DIV);
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            rem    <= '0;
                            quo    <= a;
                            dvsr   <= b;
                        end else begin
                            out  <= sc_out;
                            err  <= sc_err;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc    <= mul_acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= div_rem_n;
                    quo    <= div_quo_n;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        out   <= is_div ? {div_rem_n, div_quo_n}
                                        : mul_acc_n;
                        err   <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq.
// Expected results come from an integer-arithmetic model of each opcode.
module tb_alu_seq;

    localparam int W     = 6;
    localparam int HALF  = 1 << (W - 1);
    localparam int FULL  = 1 << W;
    localparam int FULL2 = 1 << (2 * W);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     func;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;
    logic           err;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_out = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .func  (func),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Wrap a signed integer to W bits, then sign-extend to 2W bits.
    function automatic int wrap_ext(input int s);
        int w;
        w = ((s % FULL) + FULL) % FULL;
        return (sx(w) + FULL2) % FULL2;
    endfunction

    function automatic void model(input int f, input int x, input int y,
                                  output int o, output int e);
        int s;
        o = 0;
        e = 0;
        case (f)
            0: begin
                s = sx(x) + sx(y);
                e = (s >= HALF || s < -HALF) ? 1 : 0;
                o = wrap_ext(s);
            end
            1: begin
                s = sx(x) - sx(y);
                e = (s >= HALF || s < -HALF) ? 1 : 0;
                o = wrap_ext(s);
            end
            2: o = x * y;
            3: begin
                if (y == 0) begin
                    o = FULL2 - 1;
                    e = 1;
                end else begin
                    o = (x % y) * FULL + (x / y);
                end
            end
            4: o = x & y;
            5: o = x | y;
            6: o = x ^ y;
            default: e = 1;
        endcase
    endfunction

    // Issue one op and check it through to its done pulse.
    task automatic do_op(input int f, input int x, input int y,
                         input bit poke, input bit hold);
        int  eo;
        int  ee;
        bit  multi;
        if (!hold) @(negedge clk);
        start = 1'b1;
        func  = 3'(f);
        a     = W'(x);
        b     = W'(y);
        model(f, x, y, eo, ee);
        multi = (f == 2) || (f == 3 && y != 0);
        @(posedge clk);
        #1;
        if (!multi) begin
            chk("sc_done", done, 1);
            chk("sc_busy", busy, 0);
            chk("sc_out", out, eo);
            chk("sc_err", err, ee);
        end else begin
            chk("mc_busy_k", busy, 1);
            chk("mc_done_k", done, 0);
            chk("mc_hold_k", out, exp_out);
            for (int i = 1; i <= W; i++) begin
                @(negedge clk);
                start = poke && (i == 3);
                func  = 3'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                @(posedge clk);
                #1;
                if (i < W) begin
                    chk("mc_busy", busy, 1);
                    chk("mc_done", done, 0);
                    chk("mc_hold_out", out, exp_out);
                    chk("mc_hold_err", err, exp_err);
                end else begin
                    chk("mc_done_end", done, 1);
                    chk("mc_busy_end", busy, 0);
                    chk("mc_out", out, eo);
                    chk("mc_err", err, ee);
                end
            end
        end
        exp_out = eo;
        exp_err = ee;
    endtask

    task automatic idle_check();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out", out, exp_out);
        chk("idle_err", err, exp_err);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        func  = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", out, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(0, 31, 1, 0, 0);
        chk("plan_add", out, 12'hFE0);
        idle_check();
        do_op(1, 32, 1, 0, 0);
        chk("plan_sub", out, 12'h01F);
        idle_check();
        do_op(2, 63, 63, 1, 0);
        chk("plan_mul", out, 12'hF81);
        idle_check();
        do_op(3, 45, 7, 0, 0);
        chk("plan_div", out, 12'h0C6);
        idle_check();
        do_op(3, 9, 0, 0, 0);
        chk("plan_div0", out, 12'hFFF);
        idle_check();
        do_op(4, 'h2A, 'h0F, 0, 0);
        chk("plan_and", out, 12'h00A);
        do_op(6, 'h2A, 'h0F, 0, 0);
        chk("plan_xor", out, 12'h025);
        do_op(7, 1, 2, 0, 0);
        chk("plan_ill_err", err, 1);
        idle_check();

        @(negedge clk);
        start = 1'b1;
        func  = 3'd2;
        a     = W'(5);
        b     = W'(5);
        @(posedge clk);
        #1;
        chk("rmul_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_done", done, 0);
        chk("rmid_out", out, 0);
        chk("rmid_err", err, 0);
        exp_out = 0;
        exp_err = 0;
        @(posedge clk);
        #1;
        chk("rmid_done2", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("rpost_done", done, 0);
            chk("rpost_busy", busy, 0);
        end
        do_op(2, 5, 5, 0, 0);
        chk("plan_rmul", out, 12'h019);
        idle_check();

        do_op(0, 3, 4, 0, 0);
        chk("b2b_add", out, 12'h007);
        do_op(2, 2, 3, 0, 1);
        chk("b2b_mul", out, 12'h006);
        idle_check();

        repeat (300) begin
            int f;
            int x;
            int y;
            f = $urandom_range(0, 7);
            x = $urandom_range(0, FULL - 1);
            y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, FULL - 1);
            do_op(f, x, y, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
